// File: rtl/interp_stream_engine.sv
// Streaming NB-IoT channel-estimate interpolator: loads NUM_PILOTS pilots, emits 3*NUM_PILOTS estimates.
// Optional macro INTERP_SAT_FLAG_EN adds m_sat, flagging samples clipped to the output range.
module interp_stream_engine #(
    parameter int IN_WIDTH   = 17,
    parameter int OUT_WIDTH  = 17,
    parameter int NUM_PILOTS = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  v_shift,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [IN_WIDTH-1:0]  s_re,
    input  logic signed [IN_WIDTH-1:0]  s_im,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [OUT_WIDTH-1:0] m_re,
    output logic signed [OUT_WIDTH-1:0] m_im,
    output logic [IDX_WIDTH-1:0]        m_idx,
    output logic                        m_last
`ifdef INTERP_SAT_FLAG_EN
    ,
    output logic                        m_sat
`endif
);

    localparam int NSC = 3 * NUM_PILOTS;
    localparam int NW  = IN_WIDTH + 3;
    localparam int PW  = $clog2(NUM_PILOTS);
    localparam logic [PW-1:0]        LAST_K  = PW'(NUM_PILOTS - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_N  = IDX_WIDTH'(NSC - 1);
    localparam logic signed [NW-1:0] SAT_MAX = NW'((1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [NW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ST_LOAD, ST_OUT} state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               k_q, k_d;
    logic [1:0]                  vs_q, vs_d;
    logic [IDX_WIDTH-1:0]        n_q, n_d;
    logic                        s_ready_q, s_ready_d;
    logic                        m_valid_q, m_valid_d;
    logic signed [OUT_WIDTH-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
    logic                        m_last_q, m_last_d;
    logic signed [IN_WIDTH-1:0]  p_q [2][NUM_PILOTS];
    logic signed [IN_WIDTH-1:0]  p_d [2][NUM_PILOTS];
    logic signed [IN_WIDTH-1:0]  p_eff [2][NUM_PILOTS];
    logic signed [OUT_WIDTH-1:0] lane_res [2];
`ifdef INTERP_SAT_FLAG_EN
    logic                        m_sat_q, m_sat_d;
    logic                        lane_clip [2];
`endif

    logic                 load_fire, out_fire;
    logic [1:0]           vs_in, vs_eff;
    logic [IDX_WIDTH-1:0] n_sel;
    logic [PW-1:0]        a_sel, b_sel;
    logic [2:0]           wa;
    logic [1:0]           wb;
    logic                 wb_neg;

    // Long division by 3 using only compare/subtract.
    function automatic logic [NW-1:0] div3(input logic [NW-1:0] x);
        logic [NW-1:0] q;
        logic [2:0]    rem;
        q   = '0;
        rem = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            rem = {rem[1:0], x[i]};
            if (rem >= 3'd3) begin
                rem  = rem - 3'd3;
                q[i] = 1'b1;
            end
        end
        return q;
    endfunction

    assign load_fire = s_valid && s_ready_q;
    assign out_fire  = m_valid_q && m_ready;
    assign vs_in     = (v_shift == 2'd3) ? 2'd0 : v_shift;
    assign vs_eff    = (load_fire && k_q == '0) ? vs_in : vs_q;
    assign n_sel     = (state_q == ST_LOAD) ? '0 : n_q + IDX_WIDTH'(1);

    // Pilot view including the one being accepted this cycle, so sample 0 is ready on the last accept.
    for (genvar gi = 0; gi < NUM_PILOTS; gi++) begin : g_pilot
        assign p_eff[0][gi] = (load_fire && k_q == PW'(gi)) ? s_re : p_q[0][gi];
        assign p_eff[1][gi] = (load_fire && k_q == PW'(gi)) ? s_im : p_q[1][gi];
    end

    // Choose the two contributing pilots and their weights for subcarrier n_sel.
    always_comb begin
        int n_i, vs_i, r_i, k_i, d_i;
        n_i    = int'(n_sel);
        vs_i   = int'(vs_eff);
        r_i    = 0;
        k_i    = 0;
        d_i    = 0;
        a_sel  = '0;
        b_sel  = '0;
        wa     = 3'd3;
        wb     = 2'd0;
        wb_neg = 1'b0;
        if (n_i < vs_i) begin
            d_i    = vs_i - n_i;
            a_sel  = PW'(0);
            b_sel  = PW'(1);
            wa     = 3'(3 + d_i);
            wb     = 2'(d_i);
            wb_neg = 1'b1;
        end else begin
            r_i = n_i - vs_i;
            for (int i = 1; i < NUM_PILOTS; i++) begin
                if (r_i >= 3 * i) k_i = i;
            end
            d_i = r_i - 3 * k_i;
            if (k_i == NUM_PILOTS - 1 && d_i > 0) begin
                a_sel  = PW'(NUM_PILOTS - 1);
                b_sel  = PW'(NUM_PILOTS - 2);
                wa     = 3'(3 + d_i);
                wb     = 2'(d_i);
                wb_neg = 1'b1;
            end else if (d_i > 0) begin
                a_sel = PW'(k_i);
                b_sel = PW'(k_i + 1);
                wa    = 3'(3 - d_i);
                wb    = 2'(d_i);
            end else begin
                a_sel = PW'(k_i);
                b_sel = PW'(k_i);
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [IN_WIDTH-1:0] a_p, b_p;
        logic signed [NW-1:0]       a_x, b_x, a_t, b_t, num, quo;
        logic [NW-1:0]              mag, q_u;

        assign a_p = p_eff[gi][a_sel];
        assign b_p = p_eff[gi][b_sel];
        assign a_x = {{3{a_p[IN_WIDTH-1]}}, a_p};
        assign b_x = {{3{b_p[IN_WIDTH-1]}}, b_p};

        always_comb begin
            a_t = '0;
            b_t = '0;
            case (wa)
                3'd1:    a_t = a_x;
                3'd2:    a_t = a_x <<< 1;
                3'd3:    a_t = (a_x <<< 1) + a_x;
                3'd4:    a_t = a_x <<< 2;
                3'd5:    a_t = (a_x <<< 2) + a_x;
                default: a_t = '0;
            endcase
            case (wb)
                2'd1:    b_t = b_x;
                2'd2:    b_t = b_x <<< 1;
                default: b_t = '0;
            endcase
        end

        // Round-to-nearest on the magnitude: remainders are only 0, 1/3, 2/3.
        assign num = wb_neg ? a_t - b_t : a_t + b_t;
        assign mag = num[NW-1] ? NW'(-num) : NW'(num);
        assign q_u = div3(mag + NW'(1));
        assign quo = num[NW-1] ? -$signed(q_u) : $signed(q_u);

        assign lane_res[gi] = (quo > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
                              (quo < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] :
                                                quo[OUT_WIDTH-1:0];
`ifdef INTERP_SAT_FLAG_EN
        assign lane_clip[gi] = (quo > SAT_MAX) || (quo < SAT_MIN);
`endif
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        vs_d      = vs_eff;
        n_d       = n_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_re_d    = m_re_q;
        m_im_d    = m_im_q;
        m_last_d  = m_last_q;
        p_d       = p_eff;
`ifdef INTERP_SAT_FLAG_EN
        m_sat_d   = m_sat_q;
`endif
        case (state_q)
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (load_fire) begin
                    if (k_q == LAST_K) begin
                        state_d   = ST_OUT;
                        k_d       = '0;
                        s_ready_d = 1'b0;
                        m_valid_d = 1'b1;
                        n_d       = '0;
                        m_re_d    = lane_res[0];
                        m_im_d    = lane_res[1];
                        m_last_d  = 1'b0;
`ifdef INTERP_SAT_FLAG_EN
                        m_sat_d   = lane_clip[0] || lane_clip[1];
`endif
                    end else begin
                        k_d = k_q + PW'(1);
                    end
                end
            end
            default: begin
                if (out_fire) begin
                    if (m_last_q) begin
                        state_d   = ST_LOAD;
                        m_valid_d = 1'b0;
                        s_ready_d = 1'b1;
                        m_last_d  = 1'b0;
                        n_d       = '0;
                    end else begin
                        n_d      = n_sel;
                        m_re_d   = lane_res[0];
                        m_im_d   = lane_res[1];
                        m_last_d = (n_sel == LAST_N);
`ifdef INTERP_SAT_FLAG_EN
                        m_sat_d  = lane_clip[0] || lane_clip[1];
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            k_q       <= '0;
            vs_q      <= '0;
            n_q       <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_re_q    <= '0;
            m_im_q    <= '0;
            m_last_q  <= 1'b0;
            for (int i = 0; i < NUM_PILOTS; i++) begin
                p_q[0][i] <= '0;
                p_q[1][i] <= '0;
            end
`ifdef INTERP_SAT_FLAG_EN
            m_sat_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            vs_q      <= vs_d;
            n_q       <= n_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_re_q    <= m_re_d;
            m_im_q    <= m_im_d;
            m_last_q  <= m_last_d;
            p_q       <= p_d;
`ifdef INTERP_SAT_FLAG_EN
            m_sat_q   <= m_sat_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_re    = m_re_q;
    assign m_im    = m_im_q;
    assign m_idx   = n_q;
    assign m_last  = m_last_q;
`ifdef INTERP_SAT_FLAG_EN
    assign m_sat   = m_sat_q;
`endif

endmodule

// File: tb/tb_interp_stream_engine.sv
// Directed bench for interp_stream_engine: interpolation, rounding, saturation, backpressure, reset.
module tb_interp_stream_engine;

    localparam int IW  = 17;
    localparam int OW  = 17;
    localparam int NP  = 4;
    localparam int IXW = 4;
    localparam int NSC = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           v_shift = 2'd0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [IW-1:0] s_re = '0;
    logic signed [IW-1:0] s_im = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic signed [OW-1:0] m_re, m_im;
    logic [IXW-1:0]       m_idx;
    logic                 m_last;
`ifdef INTERP_SAT_FLAG_EN
    logic                 m_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pil_re [NP];
    int pil_im [NP];
    int exp_re [NSC];
    int exp_im [NSC];
    int exp_sat [NSC];

    always #5 clk = ~clk;

    interp_stream_engine #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_PILOTS(NP), .IDX_WIDTH(IXW)
    ) dut (
        .clk(clk), .rst(rst), .v_shift(v_shift),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last)
`ifdef INTERP_SAT_FLAG_EN
        , .m_sat(m_sat)
`endif
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last pilot is taken.
    task automatic send_block(input int vs);
        int w;
        v_shift = 2'(vs);
        for (int k = 0; k < NP; k++) begin
            s_valid = 1'b1;
            s_re    = IW'(pil_re[k]);
            s_im    = IW'(pil_im[k]);
            w = 0;
            while (!s_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!s_ready) check("s_ready_timeout", s_ready, 1);
            @(negedge clk);
            if (k == 0) v_shift = 2'(vs ^ 1);
        end
        s_valid = 1'b0;
        check("first_valid", m_valid, 1);
        check("first_s_ready", s_ready, 0);
        check("first_idx", m_idx, 0);
    endtask

    task automatic collect(input int hold_at);
        int got;
        int hold;
        got  = 0;
        hold = (hold_at >= 0) ? 3 : 0;
        for (int cyc = 0; cyc < 200 && got < NSC; cyc++) begin
            if (m_valid) begin
                if (hold > 0 && int'(m_idx) == hold_at) begin
                    m_ready = 1'b0;
                    check("hold_idx", m_idx, hold_at);
                    check("hold_re", m_re, exp_re[hold_at]);
                    check("hold_im", m_im, exp_im[hold_at]);
                    hold--;
                end else begin
                    m_ready = 1'b1;
                    check("idx", m_idx, got);
                    check("re", m_re, exp_re[got]);
                    check("im", m_im, exp_im[got]);
                    check("last", m_last, (got == NSC - 1) ? 1 : 0);
`ifdef INTERP_SAT_FLAG_EN
                    check("sat", m_sat, exp_sat[got]);
`endif
                    $display("tx n=%0d re=%0d im=%0d last=%0b", m_idx, m_re, m_im, m_last);
                    got++;
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("handshakes", got, NSC);
        check("end_m_valid", m_valid, 0);
        check("end_s_ready", s_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_re", m_re, 0);
        check("rst_m_im", m_im, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);

        // Linear ramp, VS=0; extrapolation continues the slope above the last pilot.
        pil_re = '{0, 300, 600, 900};
        pil_im = '{-50, -50, -50, -50};
        for (int n = 0; n < NSC; n++) begin
            exp_re[n] = 100 * n; exp_im[n] = -50; exp_sat[n] = 0;
        end
        send_block(0);
        collect(-1);

        // VS=2 with s_valid held high during output (must be ignored).
        pil_re = '{300, 600, 900, 1200};
        pil_im = '{10, 20, 30, 40};
        exp_im = '{3, 7, 10, 13, 17, 20, 23, 27, 30, 33, 37, 40};
        for (int n = 0; n < NSC; n++) begin
            exp_re[n] = 100 * (n + 1); exp_sat[n] = 0;
        end
        send_block(2);
        s_valid = 1'b1;
        s_re    = IW'(12345);
        s_im    = IW'(-777);
        collect(-1);

        // Rounding of thirds, VS=0.
        pil_re = '{0, 1, 0, -1};
        pil_im = '{0, 0, 0, 0};
        exp_re = '{0, 0, 1, 1, 1, 0, 0, 0, -1, -1, -1, -2};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_sat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_block(0);
        collect(-1);

        // Saturation both directions, VS=0.
        pil_re = '{0, 0, -65536, 65535};
        pil_im = '{0, 0, 65535, -65536};
        exp_re = '{0, 0, 0, 0, -21845, -43691, -65536, -21846, 21845, 65535, 65535, 65535};
        exp_im = '{0, 0, 0, 0, 21845, 43690, 65535, 21845, -21846, -65536, -65536, -65536};
        exp_sat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        send_block(0);
        collect(-1);

        // Backpressure: m_ready low for 3 cycles while n=5 is presented.
        pil_re = '{0, 300, 600, 900};
        pil_im = '{-50, -50, -50, -50};
        for (int n = 0; n < NSC; n++) begin
            exp_re[n] = 100 * n; exp_im[n] = -50; exp_sat[n] = 0;
        end
        send_block(0);
        collect(5);

        // Reset mid-stream at n=7, then a fresh VS=2 block.
        send_block(0);
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && int'(m_idx) != 7; cyc++) @(negedge clk);
        check("reach_n7", m_idx, 7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_m_idx", m_idx, 0);
        check("midrst_m_re", m_re, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_s_ready", s_ready, 1);
        check("midrst_release_m_valid", m_valid, 0);
        pil_re = '{300, 600, 900, 1200};
        pil_im = '{10, 20, 30, 40};
        exp_im = '{3, 7, 10, 13, 17, 20, 23, 27, 30, 33, 37, 40};
        for (int n = 0; n < NSC; n++) begin
            exp_re[n] = 100 * (n + 1); exp_sat[n] = 0;
        end
        send_block(2);
        collect(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
